top_core: RTL and testbench

Registered W-bit adder datapath that sums two operands through a two-stage pipeline and presents the wrapped sum on a registered output. It is the top-level compute block of the X-propagation evaluation design. The block is used to check that an unknown reset value is handled pessimistically in simulation and that the block recovers cleanly after a valid reset.

---
 rtl/top_core.sv | 47 ++++
 tb/tb_top_core.sv | 124 ++++++++++++
 2 files changed

// File: rtl/top_core.sv
// rtl/top_core.sv - two-stage registered W-bit wrapping adder
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous active-high reset; clears every pipeline register
//   operand_A   first addend, captured every edge
//   operand_B   second addend, captured every edge
//   result_data (A + B) mod 2^W, two edges after the operands were sampled

module top_core #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] operand_A,
    input  logic [W-1:0] operand_B,
    output logic [W-1:0] result_data
);

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] result_q;

    // The reset decision is written as two explicit tests so that an
    // unknown reset falls into the last branch and poisons the whole
    // pipeline instead of quietly behaving as "not in reset". Hardware
    // only ever sees a known reset, so that branch never matters there.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else if (!reset) begin
            a_q      <= operand_A;
            b_q      <= operand_B;
            // Carry-out is dropped on purpose: the sum wraps modulo 2^W.
            result_q <= a_q + b_q;
        end else begin
            a_q      <= 'x;
            b_q      <= 'x;
            result_q <= 'x;
        end
    end

    assign result_data = result_q;

endmodule

// File: tb/tb_top_core.sv
// tb/tb_top_core.sv - directed self-checking bench for top_core

module tb_top_core;

    logic        clk;
    logic        reset;
    logic [15:0] operand_A;
    logic [15:0] operand_B;
    logic [15:0] result_data;

    int total;
    int bad;
    bit four_state;
    logic probe;

    top_core #(.W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .result_data (result_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then return at the following falling edge so
    // that sampling and driving happen away from the active edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        probe = 1'bx;
        four_state = (probe === 1'bx);

        reset = 1'b1;
        operand_A = 16'd4;
        operand_B = 16'd7;
        @(negedge clk);

        // Reset hold
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("reset_hold_%0d", i), result_data, 16'd0);
        end
        reset = 1'b0;
        step(1);
        check("release_edge1", result_data, 16'd0);
        step(1);
        check("release_edge2", result_data, 16'd11);

        // Streaming
        operand_A = 16'd10; operand_B = 16'd2;
        step(1);
        check("stream1_edge1", result_data, 16'd11);
        step(1);
        check("stream1_edge2", result_data, 16'd12);
        operand_A = 16'd0; operand_B = 16'd6;
        step(2);
        check("stream2", result_data, 16'd6);
        operand_A = 16'd9; operand_B = 16'd9;
        step(2);
        check("stream3", result_data, 16'd18);

        // Wrap-around
        operand_A = 16'hFFFF; operand_B = 16'h0002;
        step(2);
        check("wrap", result_data, 16'h0001);
        operand_A = 16'h8000; operand_B = 16'h8000;
        step(2);
        check("wrap_zero", result_data, 16'h0000);

        // Mid-stream reset pulse
        operand_A = 16'd22; operand_B = 16'd21;
        step(2);
        check("pre_pulse", result_data, 16'd43);
        reset = 1'b1;
        step(1);
        check("pulse", result_data, 16'd0);
        reset = 1'b0;
        step(1);
        check("post_pulse_edge1", result_data, 16'd0);
        step(1);
        check("post_pulse_edge2", result_data, 16'd43);

        // Unknown reset
        reset = 1'bx;
        step(1);
        if (four_state) check("x_reset", result_data, 16'hxxxx);
        reset = 1'b0;
        step(1);
        if (four_state) check("x_reset_refill1", result_data, 16'hxxxx);
        step(1);
        check("x_reset_refill2", result_data, 16'd43);
        reset = 1'b1;
        step(1);
        check("x_reset_clear", result_data, 16'd0);
        reset = 1'b0;

        // Unknown operand
        operand_A = 16'hxxxx; operand_B = 16'd5;
        step(2);
        if (four_state) check("x_operand", result_data, 16'hxxxx);
        operand_A = 16'd3;
        step(2);
        check("x_operand_recover", result_data, 16'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
